// File: rtl/exec_stage_mc.sv
// Execution stage: N-way operand forwarding, single-cycle ALU, multi-cycle signed multiply, condition flags.
// Latency: ALU ops 1 cycle from accept; MUL exactly MUL_LAT cycles from accept when the output is free.
// Backpressure: oReady drops while a multiply is in flight or a held result is not being drained.
//
// Ports:
//   iClk, iRst_n                 clock, synchronous active-low reset
//   iValid / oReady              issue handshake; op fields iOp, iSrc0/1, iImm, iUseImm, iFlagEn, iWriteAddr/En
//   iFwdData0/1, iFwdSel0/1      forwarding buses (slice k = source k) and selects (0 = register operand)
//   oValid / iReady              result handshake; oResult, oWriteAddr, oWriteEn
//   oZeroFlag/oNegativeFlag/oOverflowFlag  persistent condition flags
//   oBusy                        multiply in flight
module exec_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int FWD_SRCS = 2,
    parameter int MUL_LAT  = 3,
    parameter int REG_W    = 5
) (
    input  logic                                iClk,
    input  logic                                iRst_n,
    input  logic                                iValid,
    output logic                                oReady,
    input  logic [2:0]                          iOp,
    input  logic [DATA_W-1:0]                   iSrc0,
    input  logic [DATA_W-1:0]                   iSrc1,
    input  logic [DATA_W-1:0]                   iImm,
    input  logic                                iUseImm,
    input  logic [FWD_SRCS*DATA_W-1:0]          iFwdData0,
    input  logic [$clog2(FWD_SRCS+1)-1:0]       iFwdSel0,
    input  logic [FWD_SRCS*DATA_W-1:0]          iFwdData1,
    input  logic [$clog2(FWD_SRCS+1)-1:0]       iFwdSel1,
    input  logic [2:0]                          iFlagEn,
    input  logic [REG_W-1:0]                    iWriteAddr,
    input  logic                                iWriteEn,
    output logic                                oValid,
    input  logic                                iReady,
    output logic [DATA_W-1:0]                   oResult,
    output logic [REG_W-1:0]                    oWriteAddr,
    output logic                                oWriteEn,
    output logic                                oZeroFlag,
    output logic                                oNegativeFlag,
    output logic                                oOverflowFlag,
    output logic                                oBusy
);

    localparam int SEL_W = $clog2(FWD_SRCS + 1);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_LAT);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE, MUL_WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   mulCnt;
    logic [DATA_W-1:0]  mulA;
    logic [DATA_W-1:0]  mulB;
    logic [REG_W-1:0]   mulAddr;
    logic               mulWen;
    logic [2:0]         mulFlagEn;

    logic [DATA_W-1:0]  opA;
    logic [DATA_W-1:0]  fwdB;
    logic [DATA_W-1:0]  opB;
    logic [DATA_W-1:0]  aluRes;
    logic               aluOvf;

    // Operand mux: selects above FWD_SRCS match no source and fall back to the register operand.
    always_comb begin
        opA  = iSrc0;
        fwdB = iSrc1;
        for (int k = 0; k < FWD_SRCS; k++) begin
            if (iFwdSel0 == SEL_W'(k + 1)) opA  = iFwdData0[k*DATA_W +: DATA_W];
            if (iFwdSel1 == SEL_W'(k + 1)) fwdB = iFwdData1[k*DATA_W +: DATA_W];
        end
    end

    assign opB = iUseImm ? iImm : fwdB;

    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        case (iOp)
            OP_ADD: begin
                aluRes = opA + opB;
                aluOvf = (opA[DATA_W-1] == opB[DATA_W-1]) && (aluRes[DATA_W-1] != opA[DATA_W-1]);
            end
            OP_SUB: begin
                aluRes = opA - opB;
                aluOvf = (opA[DATA_W-1] != opB[DATA_W-1]) && (aluRes[DATA_W-1] != opA[DATA_W-1]);
            end
            OP_AND:  aluRes = opA & opB;
            OP_OR:   aluRes = opA | opB;
            OP_XOR:  aluRes = opA ^ opB;
            OP_SLL:  aluRes = opA << opB[SH_W-1:0];
            OP_SRL:  aluRes = opA >> opB[SH_W-1:0];
            default: aluRes = '0;
        endcase
    end

    // Full-width signed product of the latched operands; only consumed at the end of MUL_WAIT.
    logic [2*DATA_W-1:0] mulAExt;
    logic [2*DATA_W-1:0] mulBExt;
    logic [2*DATA_W-1:0] mulProd;
    logic                mulOvf;

    assign mulAExt = {{DATA_W{mulA[DATA_W-1]}}, mulA};
    assign mulBExt = {{DATA_W{mulB[DATA_W-1]}}, mulB};
    assign mulProd = mulAExt * mulBExt;
    assign mulOvf  = mulProd[2*DATA_W-1:DATA_W] != {DATA_W{mulProd[DATA_W-1]}};

    logic               outFree;
    logic               accept;
    logic               mulDone;
    logic               load;
    logic [DATA_W-1:0]  loadRes;
    logic               loadOvf;
    logic [2:0]         loadFlagEn;
    logic [REG_W-1:0]   loadAddr;
    logic               loadWen;

    assign outFree = !oValid || iReady;
    assign oReady  = (state == IDLE) && outFree;
    assign accept  = iValid && oReady;
    assign mulDone = (state == MUL_WAIT) && (mulCnt == '0) && outFree;
    assign load    = (accept && (iOp != OP_MUL)) || mulDone;

    // accept only happens in IDLE and mulDone only in MUL_WAIT, so the two sources never collide.
    assign loadRes    = mulDone ? mulProd[DATA_W-1:0] : aluRes;
    assign loadOvf    = mulDone ? mulOvf              : aluOvf;
    assign loadFlagEn = mulDone ? mulFlagEn           : iFlagEn;
    assign loadAddr   = mulDone ? mulAddr             : iWriteAddr;
    assign loadWen    = mulDone ? mulWen              : iWriteEn;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state         <= IDLE;
            mulCnt        <= '0;
            mulA          <= '0;
            mulB          <= '0;
            mulAddr       <= '0;
            mulWen        <= 1'b0;
            mulFlagEn     <= '0;
            oBusy         <= 1'b0;
            oValid        <= 1'b0;
            oResult       <= '0;
            oWriteAddr    <= '0;
            oWriteEn      <= 1'b0;
            oZeroFlag     <= 1'b0;
            oNegativeFlag <= 1'b0;
            oOverflowFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (iOp == OP_MUL)) begin
                        state     <= MUL_WAIT;
                        mulCnt    <= CNT_W'(MUL_LAT - 1);
                        mulA      <= opA;
                        mulB      <= opB;
                        mulAddr   <= iWriteAddr;
                        mulWen    <= iWriteEn;
                        mulFlagEn <= iFlagEn;
                        oBusy     <= 1'b1;
                    end
                end
                MUL_WAIT: begin
                    // At count 0 the product waits here until the output register can take it.
                    if (mulCnt != '0) begin
                        mulCnt <= mulCnt - CNT_W'(1);
                    end else if (outFree) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                oValid     <= 1'b1;
                oResult    <= loadRes;
                oWriteAddr <= loadAddr;
                oWriteEn   <= loadWen;
                if (loadFlagEn[0]) oZeroFlag     <= (loadRes == '0);
                if (loadFlagEn[1]) oNegativeFlag <= loadRes[DATA_W-1];
                if (loadFlagEn[2]) oOverflowFlag <= loadOvf;
            end else if (iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_mc.sv
module tb_exec_stage_mc;

    localparam int DW = 32;
    localparam int FS = 2;
    localparam int ML = 3;
    localparam int RW = 5;

    logic            iClk;
    logic            iRst_n;
    logic            iValid;
    logic            oReady;
    logic [2:0]      iOp;
    logic [DW-1:0]   iSrc0, iSrc1, iImm;
    logic            iUseImm;
    logic [FS*DW-1:0] iFwdData0, iFwdData1;
    logic [1:0]      iFwdSel0, iFwdSel1;
    logic [2:0]      iFlagEn;
    logic [RW-1:0]   iWriteAddr;
    logic            iWriteEn;
    logic            oValid;
    logic            iReady;
    logic [DW-1:0]   oResult;
    logic [RW-1:0]   oWriteAddr;
    logic            oWriteEn;
    logic            oZeroFlag, oNegativeFlag, oOverflowFlag;
    logic            oBusy;

    exec_stage_mc #(.DATA_W(DW), .FWD_SRCS(FS), .MUL_LAT(ML), .REG_W(RW)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady), .iOp(iOp),
        .iSrc0(iSrc0), .iSrc1(iSrc1), .iImm(iImm), .iUseImm(iUseImm),
        .iFwdData0(iFwdData0), .iFwdSel0(iFwdSel0), .iFwdData1(iFwdData1), .iFwdSel1(iFwdSel1),
        .iFlagEn(iFlagEn), .iWriteAddr(iWriteAddr), .iWriteEn(iWriteEn),
        .oValid(oValid), .iReady(iReady), .oResult(oResult), .oWriteAddr(oWriteAddr),
        .oWriteEn(oWriteEn), .oZeroFlag(oZeroFlag), .oNegativeFlag(oNegativeFlag),
        .oOverflowFlag(oOverflowFlag), .oBusy(oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [DW-1:0] res;
        logic [RW-1:0] wa;
        logic          we;
        logic [2:0]    fl;   // {overflow, negative, zero}
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic mz = 1'b0, mn = 1'b0, mv = 1'b0;
    bit   randReady = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void calc(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output logic [DW-1:0] r, output logic v);
        longint sa, sb, full, lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        full = 0;
        v = 1'b0;
        case (op)
            3'd0: begin full = sa + sb; r = full[DW-1:0]; v = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
            3'd1: begin full = sa - sb; r = full[DW-1:0]; v = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: begin
                full = sa * sb;
                r = full[DW-1:0];
                lo = longint'($signed(r));
                v = (full != lo);
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] src,
                                           input logic [FS*DW-1:0] bus);
        case (sel)
            2'd1:    return bus[DW-1:0];
            2'd2:    return bus[2*DW-1:DW];
            default: return src;
        endcase
    endfunction

    // Expected result for the op currently on the issue inputs; flags evolve in accept order.
    task automatic push_exp();
        logic [DW-1:0] a, b, r;
        logic v;
        exp_t e;
        a = pick(iFwdSel0, iSrc0, iFwdData0);
        b = iUseImm ? iImm : pick(iFwdSel1, iSrc1, iFwdData1);
        calc(iOp, a, b, r, v);
        if (iFlagEn[0]) mz = (r == '0);
        if (iFlagEn[1]) mn = r[DW-1];
        if (iFlagEn[2]) mv = v;
        e.res = r; e.wa = iWriteAddr; e.we = iWriteEn; e.fl = {mv, mn, mz};
        expq.push_back(e);
    endtask

    // Called at a negedge with the op fields set; returns at the negedge after acceptance.
    task automatic issue();
        iValid = 1'b1;
        for (int n = 0; ; n++) begin
            #1;
            if (oReady) break;
            if (n >= 200) begin
                chk("accept_timeout", 64'd0, 64'd1);
                iValid = 1'b0;
                return;
            end
            @(negedge iClk);
        end
        push_exp();
        @(negedge iClk);
        iValid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return DW'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand();
        iOp        = 3'($urandom_range(0, 7));
        iSrc0      = rand_val();
        iSrc1      = rand_val();
        iImm       = rand_val();
        iUseImm    = 1'($urandom_range(0, 1));
        iFwdData0  = {rand_val(), rand_val()};
        iFwdData1  = {rand_val(), rand_val()};
        iFwdSel0   = 2'($urandom_range(0, 3));
        iFwdSel1   = 2'($urandom_range(0, 3));
        iFlagEn    = 3'($urandom_range(0, 7));
        iWriteAddr = RW'($urandom_range(0, 31));
        iWriteEn   = 1'($urandom_range(0, 1));
    endtask

    task automatic set_op(input logic [2:0] op, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                          input logic [DW-1:0] imm, input logic useImm, input logic [1:0] sel0,
                          input logic [2:0] fe, input logic [RW-1:0] wa);
        iOp = op; iSrc0 = s0; iSrc1 = s1; iImm = imm; iUseImm = useImm;
        iFwdSel0 = sel0; iFwdSel1 = 2'd0; iFlagEn = fe; iWriteAddr = wa; iWriteEn = 1'b1;
    endtask

    // Monitor: every output handshake pops and compares one expected entry.
    initial begin
        forever begin
            @(negedge iClk);
            #2;
            if (iRst_n && oValid && iReady) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", {32'd0, oResult}, 64'hXXXX);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("result", oResult, e.res);
                    chk("waddr", oWriteAddr, e.wa);
                    chk("wen", oWriteEn, e.we);
                    chk("flags", {oOverflowFlag, oNegativeFlag, oZeroFlag}, e.fl);
                end
            end
        end
    end

    always @(negedge iClk) if (randReady) iReady = ($urandom_range(0, 3) != 0);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        iRst_n = 1'b0; iValid = 1'b0; iReady = 1'b1;
        iFwdData0 = '0; iFwdData1 = '0;
        set_op(3'd0, '0, '0, '0, 1'b0, 2'd0, 3'd0, '0);
        repeat (3) @(negedge iClk);
        #1;
        chk("rst_valid", oValid, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_result", oResult, 0);
        chk("rst_flags", {oOverflowFlag, oNegativeFlag, oZeroFlag}, 0);
        chk("rst_wen", oWriteEn, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        chk("rst_ready", oReady, 1);

        // Signed overflow on ADD.
        @(negedge iClk);
        set_op(3'd0, 32'h7FFF_FFFF, '0, 32'd1, 1'b1, 2'd0, 3'b111, 5'd3);
        issue();
        #1;
        chk("add_valid", oValid, 1);
        chk("add_result", oResult, 32'h8000_0000);
        chk("add_flags", {oOverflowFlag, oNegativeFlag, oZeroFlag}, 3'b110);

        // Forwarded operand 0 with immediate operand 1.
        set_op(3'd1, 32'h1234, '0, 32'd5, 1'b1, 2'd2, 3'b111, 5'd4);
        iFwdData0 = {32'h10, 32'hDEAD};
        issue();
        #1;
        chk("fwd_sub", oResult, 32'h0B);

        // Out-of-range select falls back to iSrc0; zero result sets Z.
        set_op(3'd1, 32'd5, '0, 32'd5, 1'b1, 2'd3, 3'b111, 5'd5);
        issue();
        #1;
        chk("fwd_oor", oResult, 32'h0);
        chk("fwd_oor_z", oZeroFlag, 1);

        // MUL: busy for MUL_LAT cycles, only V enabled.
        set_op(3'd7, 32'h1_0000, 32'h1_0000, '0, 1'b0, 2'd0, 3'b100, 5'd6);
        issue();
        for (int i = 0; i < ML; i++) begin
            if (i > 0) @(negedge iClk);
            #1;
            chk("mul_busy", oBusy, 1);
            chk("mul_ready", oReady, 0);
            chk("mul_early", oValid, 0);
        end
        @(negedge iClk);
        #1;
        chk("mul_valid", oValid, 1);
        chk("mul_result", oResult, 0);
        chk("mul_flags", {oOverflowFlag, oNegativeFlag, oZeroFlag}, 3'b101);
        chk("mul_idle", oBusy, 0);

        // Backpressure: held result blocks issue, then drain and accept on the same edge.
        @(negedge iClk);
        iReady = 1'b0;
        set_op(3'd0, 32'd100, '0, 32'd23, 1'b1, 2'd0, 3'b111, 5'd7);
        issue();
        set_op(3'd0, 32'd1, '0, 32'd2, 1'b1, 2'd0, 3'b111, 5'd8);
        iValid = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_ready", oReady, 0);
            chk("bp_hold", oResult, 32'd123);
            @(negedge iClk);
        end
        iReady = 1'b1;
        #1;
        chk("bp_release_ready", oReady, 1);
        push_exp();
        @(negedge iClk);
        iValid = 1'b0;
        #1;
        chk("bp_valid_stays", oValid, 1);
        chk("bp_new_result", oResult, 32'd3);

        // MUL completing with iReady low: result appears on time and is held until drained.
        set_op(3'd7, 32'hFFFF_FFFD, 32'd7, '0, 1'b0, 2'd0, 3'b011, 5'd9);
        issue();
        iReady = 1'b0;
        repeat (ML - 1) @(negedge iClk);
        #1;
        chk("mulbp_pending", oValid, 0);
        @(negedge iClk);
        #1;
        chk("mulbp_valid", oValid, 1);
        chk("mulbp_result", oResult, 32'hFFFF_FFEB);
        held = oResult;
        repeat (2) begin
            @(negedge iClk);
            #1;
            chk("mulbp_hold_valid", oValid, 1);
            chk("mulbp_hold_result", oResult, 32'hFFFF_FFEB);
        end
        @(negedge iClk);
        iReady = 1'b1;
        @(negedge iClk);

        // Reset in the middle of a multiply discards it.
        set_op(3'd7, 32'd2, 32'd3, '0, 1'b0, 2'd0, 3'b111, 5'd10);
        issue();
        iRst_n = 1'b0;
        @(negedge iClk);
        #1;
        chk("mrst_busy", oBusy, 0);
        chk("mrst_valid", oValid, 0);
        chk("mrst_flags", {oOverflowFlag, oNegativeFlag, oZeroFlag}, 0);
        expq.delete();
        mz = 1'b0; mn = 1'b0; mv = 1'b0;
        iRst_n = 1'b1;
        #1;
        chk("mrst_ready", oReady, 1);
        @(negedge iClk);

        // Randomized traffic with random downstream backpressure.
        randReady = 1'b1;
        for (int n = 0; n < 400; n++) begin
            drive_rand();
            if ($urandom_range(0, 3) == 0) @(negedge iClk);
            else issue();
        end
        randReady = 1'b0;
        iReady = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge iClk);
            #3;
            if (expq.size() == 0) break;
        end
        chk("drain_empty", expq.size(), 0);
        @(negedge iClk);
        #1;
        chk("drain_valid", oValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
- Parametrised, handshaked successor to the single-issue execution stage.
- Selects operands through an N-way forwarding mux and executes single-cycle ALU ops or a multi-cycle multiply.
- Registers the result with a valid/ready output stage and maintains a condition-flag register.
- Sits between decode/issue and the memory stage; stalls issue while a multiply is in flight or the downstream stage back-pressures.

Parameters:
- DATA_W, 32, operand/result width (>=8, power of 2).
- FWD_SRCS, 2, number of forwarding sources per operand (>=1).
- MUL_LAT, 3, multiply latency in cycles from accept to oValid (>=2).
- REG_W, 5, register-file address width.

Ports:
- iClk  in  1  clock
- iRst_n  in  1  synchronous active-low reset
- iValid  in  1  issue has an op
- oReady  out  1  stage can accept an op this cycle
- iOp  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
- iSrc0  in  DATA_W  register operand 0
- iSrc1  in  DATA_W  register operand 1
- iImm  in  DATA_W  immediate
- iUseImm  in  1  replace forwarded operand 1 with iImm
- iFwdData0  in  FWD_SRCS*DATA_W  forwarding bus, operand 0; slice k = source k
- iFwdSel0  in  $clog2(FWD_SRCS+1)  0 = iSrc0; k = source k-1
- iFwdData1  in  FWD_SRCS*DATA_W  forwarding bus, operand 1
- iFwdSel1  in  $clog2(FWD_SRCS+1)  as iFwdSel0, for operand 1
- iFlagEn  in  3  {overflow, negative, zero} update enables
- iWriteAddr  in  REG_W  destination register
- iWriteEn  in  1  destination write enable
- oValid  out  1  result valid
- iReady  in  1  downstream accepts result
- oResult  out  DATA_W  result
- oWriteAddr  out  REG_W  registered destination
- oWriteEn  out  1  registered write enable
- oZeroFlag  out  1  zero flag
- oNegativeFlag  out  1  negative flag
- oOverflowFlag  out  1  overflow flag
- oBusy  out  1  multiply in flight

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE; counter is 0. Reset mid-multiply aborts the op and leaves no result.

Operand selection and handshake:
- Operand select is combinational. A select value greater than FWD_SRCS falls back to the register operand.
- Operand 1 is iImm when iUseImm=1; forwarding still applies to operand 0.
- oReady = (state==IDLE) && (!oValid || iReady). An op is accepted on a clock edge where iValid && oReady.

Output register:
- oValid clears when iReady && oValid and no new result is loaded that edge.
- Accept and drain may occur on the same edge. The new result then replaces the old one and oValid stays 1.
- oResult, oWriteAddr and oWriteEn hold while oValid && !iReady.

Single-cycle ops (iOp 0-6):
- Result is loaded into the output register on the accept edge (latency 1).
- SLL/SRL shift amount = operand1[$clog2(DATA_W)-1:0]; SRL is logical.

MUL:
- On accept: latch operands, destination and iFlagEn; state goes to MUL_WAIT; counter = MUL_LAT-1; oBusy=1.
- Counter decrements each cycle.
- When counter==0 and (!oValid || iReady): load the low DATA_W bits of the signed product, oValid=1, state goes to IDLE.
- Otherwise at counter 0, stay in MUL_WAIT (hold) until the output stage frees.
- Latency is exactly MUL_LAT when not back-pressured.

Flags:
- Updated on the same edge the result is loaded into the output register, each flag only if its latched enable bit is set.
- zero = (result==0); negative = result[DATA_W-1].
- Overflow for ADD/SUB = signed overflow.
- Overflow for MUL = the full 2*DATA_W signed product is not equal to the sign-extension of its low half.
- Overflow for logical ops and shifts = 0.
- Flags persist until the next enabled update.

Test Plan:
- DATA_W=32. ADD 0x7FFFFFFF + 1 with iFlagEn=3'b111, iReady=1 -> next cycle oValid=1, oResult=0x80000000, N=1, V=1, Z=0.
- iFwdSel0=2, slice 1 = 0x10, iUseImm=1, iImm=5, SUB -> oResult=0x0B. Then iFwdSel0=3 (out of range) -> uses iSrc0.
- MUL 0x10000 * 0x10000, MUL_LAT=3, iFlagEn=3'b100 -> oReady=0 and oBusy=1 for 3 cycles; oResult=0 and V=1 at accept+3; Z unchanged.
- Hold iReady=0 with oValid=1, then issue ADD -> oReady=0 and the op is not accepted; oResult stays stable. Raise iReady -> old result drains and the new op is accepted on the same edge, so oValid stays 1.
- Multiply completes while the output is stalled -> stays in MUL_WAIT past MUL_LAT; loads on the edge after iReady=1.
- Assert iRst_n=0 during MUL_WAIT -> next edge: oBusy=0, oValid=0, flags=0, oReady=1 after release.
